wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 99 +++++++++
 tb/tb_wb_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back pipeline latch plus a 32x32 register file with $0 hardwired to zero and a retire counter.
// Optional write-back-to-read bypass enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [4:0]        ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              re1_i,
  input  logic [4:0]        raddr1_i,
  input  logic              re2_i,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [31:0]       retire_cnt_o
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [4:0]        wb_wd_q,    wb_wd_d;
  logic              wb_wreg_q,  wb_wreg_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              commit;

  // A held latch never commits, so each latched entry retires exactly once.
  assign commit = wb_wreg_q && !stall_i;

  always_comb begin
    wb_wd_d      = wb_wd_q;
    wb_wreg_d    = wb_wreg_q;
    wb_wdata_d   = wb_wdata_q;
    retire_cnt_d = retire_cnt_q;
    if (flush_i) begin
      wb_wd_d    = '0;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = '0;
    end else if (!stall_i) begin
      wb_wd_d    = ex_wd_i;
      wb_wreg_d  = ex_wreg_i;
      wb_wdata_d = ex_wdata_i;
    end
    if (commit) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd_q      <= '0;
      wb_wreg_q    <= 1'b0;
      wb_wdata_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_wd_q      <= wb_wd_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_wdata_q   <= wb_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (commit && (wb_wd_q != 5'd0)) begin
      regs_q[wb_wd_q] <= wb_wdata_q;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!rst && re && (addr != 5'd0)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_wreg_q && (wb_wd_q == addr)) val = wb_wdata_q;
      else                                val = regs_q[addr];
`else
      val = regs_q[addr];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i);
    rdata2_o = read_port(re2_i, raddr2_i);
  end

  assign wb_wd_o      = wb_wd_q;
  assign wb_wreg_o    = wb_wreg_q;
  assign wb_wdata_o   = wb_wdata_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] retire_cnt_o;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  wb_regfile #(.REG_NUM(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .re2_i(re2_i), .raddr2_i(raddr2_i),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Behavioural model: architectural register contents, one pending write-back entry, retire count.
  logic [31:0] m_regs [32];
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0; m_cnt = 32'd0;
    end else begin
      if (m_wreg && !stall_i) begin
        if (m_wd != 5'd0) m_regs[m_wd] = m_wdata;
        m_cnt = m_cnt + 32'd1;
      end
      if (flush_i) begin
        m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0;
      end else if (!stall_i) begin
        m_wd = ex_wd_i; m_wreg = ex_wreg_i; m_wdata = ex_wdata_i;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'd0;
    if (BYP && m_wreg && m_wd == a) return m_wdata;
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (!done) begin
      chk("cyc_wd",     {27'd0, wb_wd_o},   {27'd0, m_wd});
      chk("cyc_wreg",   {31'd0, wb_wreg_o}, {31'd0, m_wreg});
      chk("cyc_wdata",  wb_wdata_o,         m_wdata);
      chk("cyc_retire", retire_cnt_o,       m_cnt);
      chk("cyc_rdata1", rdata1_o,           exp_rd(re1_i, raddr1_i));
      chk("cyc_rdata2", rdata2_o,           exp_rd(re2_i, raddr2_i));
    end
  end

  task automatic idle();
    stall_i = 1'b0; flush_i = 1'b0;
    ex_wd_i = 5'd0; ex_wreg_i = 1'b0; ex_wdata_i = 32'd0;
  endtask

  task automatic drive(input logic [4:0] wd, input logic [31:0] d);
    ex_wd_i = wd; ex_wreg_i = 1'b1; ex_wdata_i = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd0; raddr2_i = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_retire", retire_cnt_o, 32'd0);
    chk("reset_wreg", {31'd0, wb_wreg_o}, 32'd0);
    rst = 1'b0;

    // Reset discards array contents
    drive(5'd5, 32'h1234);
    @(negedge clk); idle();
    @(negedge clk); raddr1_i = 5'd5; #1;
    chk("pre_rst_r5", rdata1_o, 32'h1234);
    chk("pre_rst_cnt", retire_cnt_o, 32'd1);
    #1 rst = 1'b1; #1;
    chk("rst_async_rd", rdata1_o, 32'd0);
    chk("rst_async_cnt", retire_cnt_o, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_r5", rdata1_o, 32'd0);
    chk("post_rst_cnt", retire_cnt_o, 32'd0);

    // Basic write/read of r3
    drive(5'd3, 32'hDEADBEEF); raddr1_i = 5'd3;
    @(negedge clk); idle(); #1;
    chk("r3_after_N", rdata1_o, BYP ? 32'hDEADBEEF : 32'd0);
    @(negedge clk); #1;
    chk("r3_after_N1", rdata1_o, 32'hDEADBEEF);
    chk("r3_cnt", retire_cnt_o, 32'd1);

    // $0 stays zero but still retires
    drive(5'd0, 32'hFFFFFFFF); raddr1_i = 5'd0; raddr2_i = 5'd0;
    @(negedge clk); idle();
    @(negedge clk); #1;
    chk("r0_p1", rdata1_o, 32'd0);
    chk("r0_p2", rdata2_o, 32'd0);
    chk("r0_cnt", retire_cnt_o, 32'd2);

    // Stall defers commit; exactly one commit on release
    drive(5'd7, 32'h55); raddr1_i = 5'd7;
    @(negedge clk); idle(); stall_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("stall_r7", rdata1_o, BYP ? 32'h55 : 32'd0);
    chk("stall_cnt", retire_cnt_o, 32'd2);
    chk("stall_wd", {27'd0, wb_wd_o}, 32'd7);
    stall_i = 1'b0;
    @(negedge clk); #1;
    chk("unstall_r7", rdata1_o, 32'h55);
    chk("unstall_cnt", retire_cnt_o, 32'd3);
    @(negedge clk); #1;
    chk("one_commit_cnt", retire_cnt_o, 32'd3);

    // Flush beats stall: pending entry dropped
    drive(5'd9, 32'hAA); raddr1_i = 5'd9;
    @(negedge clk); idle(); stall_i = 1'b1; flush_i = 1'b1;
    @(negedge clk); idle(); #1;
    chk("flush_stall_r9", rdata1_o, 32'd0);
    chk("flush_stall_cnt", retire_cnt_o, 32'd3);
    chk("flush_stall_wreg", {31'd0, wb_wreg_o}, 32'd0);
    @(negedge clk); #1;
    chk("flush_stall_r9_later", rdata1_o, 32'd0);

    // Flush without stall: commit of old entry still happens
    drive(5'd9, 32'hAA);
    @(negedge clk); idle(); flush_i = 1'b1;
    @(negedge clk); idle(); #1;
    chk("flush_commit_r9", rdata1_o, 32'hAA);
    chk("flush_commit_cnt", retire_cnt_o, 32'd4);
    chk("flush_commit_wreg", {31'd0, wb_wreg_o}, 32'd0);

    // Dual read and read enables
    drive(5'd1, 32'h11);
    @(negedge clk); drive(5'd2, 32'h22);
    @(negedge clk); idle();
    @(negedge clk); raddr1_i = 5'd1; raddr2_i = 5'd2; #1;
    chk("dual_p1", rdata1_o, 32'h11);
    chk("dual_p2", rdata2_o, 32'h22);
    chk("dual_cnt", retire_cnt_o, 32'd6);
    re2_i = 1'b0; #1;
    chk("re2_off", rdata2_o, 32'd0);
    re2_i = 1'b1; raddr2_i = 5'd1; #1;
    chk("same_p1", rdata1_o, 32'h11);
    chk("same_p2", rdata2_o, 32'h11);
    re1_i = 1'b0; #1;
    chk("re1_off", rdata1_o, 32'd0);
    re1_i = 1'b1;

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
